// File: rtl/fp8_e4m3_decode.sv
// FP8 E4M3 to signed Q8.8 converter with a serial left-shift normaliser.
// Optional macro FP8_DEC_SUBNORM_EN decodes subnormals instead of flushing them to zero.
module fp8_e4m3_decode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_nan,
  output logic        out_sat
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [14:0] mag;
  logic        sign;
  logic [3:0]  cnt;

  logic [3:0]  exp_f;
  logic [2:0]  man;
  logic [14:0] dec_mag;
  logic [3:0]  dec_cnt;
  logic        dec_nan;
  logic        dec_sat;
  logic [14:0] mag_shl;

  assign exp_f   = in_data[6:3];
  assign man     = in_data[2:0];
  assign mag_shl = {mag[13:0], 1'b0};

  // Gating with rst_n keeps in_ready low during reset and high right after release.
  assign in_ready = rst_n && (state == IDLE);

  // Q8.8 magnitude is {1,mmm} * 2^(e-2); exponents below 2 need a right shift instead.
  always_comb begin
    dec_mag = '0;
    dec_cnt = '0;
    dec_nan = 1'b0;
    dec_sat = 1'b0;
    if (in_data[6:0] == 7'h7F) begin
      dec_nan = 1'b1;
    end else if (exp_f >= 4'd14) begin
      dec_sat = 1'b1;
      dec_mag = 15'h7FFF;
    end else if (exp_f >= 4'd2) begin
      dec_mag = {11'd0, 1'b1, man};
      dec_cnt = exp_f - 4'd2;
    end else if (exp_f == 4'd1) begin
      dec_mag = {12'd0, 1'b1, man[2:1]};
    end else begin
`ifdef FP8_DEC_SUBNORM_EN
      dec_mag = {13'd0, man[2:1]};
`else
      dec_mag = '0;
`endif
    end
  end

  function automatic logic [15:0] apply_sign(input logic s, input logic [14:0] m);
    return s ? (16'd0 - {1'b0, m}) : {1'b0, m};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mag       <= '0;
      sign      <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_nan   <= 1'b0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign <= in_data[7];
            if (dec_cnt == 4'd0) begin
              state     <= DONE;
              out_data  <= apply_sign(in_data[7], dec_mag);
              out_nan   <= dec_nan;
              out_sat   <= dec_sat;
              out_valid <= 1'b1;
            end else begin
              state <= SHIFT;
              mag   <= dec_mag;
              cnt   <= dec_cnt;
            end
          end
        end
        SHIFT: begin
          mag <= mag_shl;
          cnt <= cnt - 4'd1;
          // The final shift lands directly in the output register.
          if (cnt == 4'd1) begin
            state     <= DONE;
            out_data  <= apply_sign(sign, mag_shl);
            out_nan   <= 1'b0;
            out_sat   <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp8_e4m3_decode.sv
// Self-checking bench for fp8_e4m3_decode: directed spec vectors, random operands
// against a real-arithmetic reference model, backpressure and mid-operation reset.
module tb_fp8_e4m3_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_nan;
  logic        out_sat;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp8_e4m3_decode dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_nan   (out_nan),
    .out_sat   (out_sat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Value * 256, truncated toward zero and clamped; latency from the exponent alone.
  function automatic void model(input logic [7:0] d, output logic [15:0] data,
                                output logic nan, output logic sat, output int n);
    int  e;
    int  m;
    int  q;
    real v;
    real sc;
    e   = int'(d[6:3]);
    m   = int'(d[2:0]);
    nan = 1'b0;
    sat = 1'b0;
    n   = 0;
    data = 16'h0000;
    if (d[6:0] == 7'h7F) begin
      nan = 1'b1;
      return;
    end
    if (e == 0) begin
`ifdef FP8_DEC_SUBNORM_EN
      v = (m / 8.0) * 4.0;
`else
      v = 0.0;
`endif
    end else begin
      sc = 1.0;
      for (int i = 0; i < e + 1; i++) sc = sc * 2.0;
      v = (1.0 + m / 8.0) * sc;
    end
    q = $rtoi(v);
    if (q > 32767) begin
      q   = 32767;
      sat = 1'b1;
    end
    if (e >= 2 && e <= 13) n = e - 2;
    data = d[7] ? 16'(-q) : 16'(q);
  endfunction

  task automatic run_op(input logic [7:0] d, input int stall, input bit has_spec,
                        input logic [15:0] spec_val);
    logic [15:0] e_data;
    logic        e_nan;
    logic        e_sat;
    int          e_n;
    int          lat;
    int          waitc;
    model(d, e_data, e_nan, e_sat, e_n);
    @(negedge clk);
    in_data   = d;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    waitc = 0;
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    chk("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(e_n + 1));
    chk("data", 32'(out_data), 32'(e_data));
    chk("nan", 32'(out_nan), 32'(e_nan));
    chk("sat", 32'(out_sat), 32'(e_sat));
    if (has_spec) chk("spec_data", 32'(out_data), 32'(spec_val));
    $display("op in=0x%02h out=0x%04h nan=%0d sat=%0d lat=%0d stall=%0d", d, out_data,
             out_nan, out_sat, lat, stall);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'(e_data));
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("done_valid_low", 32'(out_valid), 32'd0);
    chk("idle_ready", 32'(in_ready), 32'd1);
  endtask

  logic [7:0]  dir_in  [13];
  logic [15:0] dir_exp [13];

  initial begin
    int lat;
    int waitc;
    int stray;

    dir_in  = '{8'h38, 8'h40, 8'h6F, 8'hB8, 8'h00, 8'h80, 8'h08, 8'h77, 8'hF7,
                8'h7F, 8'hFF, 8'h07, 8'h87};
`ifdef FP8_DEC_SUBNORM_EN
    dir_exp = '{16'h0100, 16'h0200, 16'h7800, 16'hFF00, 16'h0000, 16'h0000, 16'h0004,
                16'h7FFF, 16'h8001, 16'h0000, 16'h0000, 16'h0003, 16'hFFFD};
`else
    dir_exp = '{16'h0100, 16'h0200, 16'h7800, 16'hFF00, 16'h0000, 16'h0000, 16'h0004,
                16'h7FFF, 16'h8001, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
`endif

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_nan", 32'(out_nan), 32'd0);
    chk("rst_out_sat", 32'(out_sat), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 13; i++) run_op(dir_in[i], i % 3, 1'b1, dir_exp[i]);

    for (int i = 0; i < 40; i++)
      run_op(8'($urandom_range(0, 255)), int'($urandom_range(0, 3)), 1'b0, 16'h0000);

    // Backpressure: result held while a second operand waits on in_valid.
    @(negedge clk);
    in_data   = 8'h38;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_data = 8'h40;
    waitc = 0;
    while (!out_valid && waitc < 30) begin
      @(negedge clk);
      waitc++;
    end
    chk("bp_first_data", 32'(out_data), 32'h0100);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_data", 32'(out_data), 32'h0100);
      chk("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("bp_second_accepted", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_second_latency", 32'(lat), 32'd7);
    chk("bp_second_data", 32'(out_data), 32'h0200);
    $display("op in=0x40 out=0x%04h after backpressure lat=%0d", out_data, lat);
    @(negedge clk);
    chk("bp_second_done", 32'(out_valid), 32'd0);

    // Reset in the middle of a long shift sequence.
    in_data   = 8'h60;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_out_nan", 32'(out_nan), 32'd0);
    chk("midrst_out_sat", 32'(out_sat), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_release_ready", 32'(in_ready), 32'd1);
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    chk("midrst_no_stale_valid", 32'(stray), 32'd0);
    chk("midrst_idle_ready", 32'(in_ready), 32'd1);
    $display("op in=0x60 aborted by reset, stray out_valid cycles=%0d", stray);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
